// File: rtl/issue_controller.sv
// In-order issue controller: scoreboard-based RAW stall, fixed-length flush after
// a taken branch/JAL in EX, and a saturating stall-cycle counter.
module issue_controller #(
    parameter int PIPE_DEPTH   = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dec_valid,
    input  logic [3:0]  dec_regno1,
    input  logic [3:0]  dec_regno2,
    input  logic        dec_use1,
    input  logic        dec_use2,
    input  logic        dec_wrtEn,
    input  logic [3:0]  dec_wrtRegno,
    input  logic        ex_redirect,
    output logic        issue,
    output logic        stall,
    output logic        flush,
    output logic [1:0]  state,
    output logic [15:0] pending,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PIPE_DEPTH-1:0] slot_v;
    logic [3:0]         slot_reg [PIPE_DEPTH];
    logic               hazard;
    logic               f;

    // ---------------------------------------------------------------- scoreboard
    // NOTE: sequential state uses non-blocking assignments so every slot samples
    // its neighbour's pre-edge value; blocking here would collapse the shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_v <= '0;
        end else begin
            slot_v[0] <= issue & dec_wrtEn;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                slot_v[i] <= slot_v[i-1];
            end
        end
    end

    // NOTE: register numbers are storage, not control; they are ignored while
    // the matching valid bit is low, so they carry no reset.
    always_ff @(posedge clk) begin
        slot_reg[0] <= dec_wrtRegno;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            slot_reg[i] <= slot_reg[i-1];
        end
    end

    // A slot stays pending through writeback: the regfile has no bypass.
    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        pending = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (slot_v[i]) begin
                pending[slot_reg[i]] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- issue logic
    assign hazard = dec_valid & ((dec_use1 & pending[dec_regno1]) |
                                 (dec_use2 & pending[dec_regno2]));
    assign f      = (state_q == FLUSH) | ex_redirect;

    // Gating with reset_n keeps the handshake quiet while reset is held.
    assign flush  = reset_n & f;
    assign issue  = reset_n & ~f & dec_valid & ~hazard;
    assign stall  = reset_n & ~f & hazard;
    assign state  = state_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN, STALL: begin
                if (ex_redirect) begin
                    if (FLUSH_CYCLES == 1) begin
                        state_d = RUN;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 2);
                    end
                end else begin
                    state_d = stall ? STALL : RUN;
                end
            end
            FLUSH: begin
                // EX holds a bubble here, so ex_redirect cannot legally occur.
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------- perf counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule
